// File: rtl/serial_pkg.sv
// Shared types and constants for the serial UART: FSM encodings and frame geometry.
package serial_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = FRAME_BITS - 2;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: held at zero while load is high, wraps every CLKS_PER_BIT cycles.
module baud_counter
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic half,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clock) begin
      if (!reset || load || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign tick = (cnt_reg == LAST_CNT);
   assign half = (cnt_reg == HALF_CNT);

endmodule

// File: rtl/serial_uart.sv
// 8N1 full-duplex UART with a one-byte receive holding register and sticky error flags.
module serial_uart
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data_in,
   input  logic       tx_wren_in,
   output logic       tx_ready_out,
   input  logic       rx_rden_in,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   output logic       rx_overrun_out,
   output logic       rx_frame_err_out
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t  tx_state_reg, tx_state_next;
   logic [7:0] tx_shift_reg, tx_shift_next;
   logic [2:0] tx_bit_reg, tx_bit_next;
   logic       tx_line_reg, tx_line_next;
   logic       tx_load, tx_tick, tx_half_unused;

   rx_state_t  rx_state_reg, rx_state_next;
   logic [7:0] rx_shift_reg, rx_shift_next;
   logic [2:0] rx_bit_reg, rx_bit_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic       rx_valid_reg, rx_valid_next;
   logic       rx_overrun_reg, rx_overrun_next;
   logic       rx_ferr_reg, rx_ferr_next;
   logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic       rx_load, rx_tick, rx_half, rx_deliver, rx_fall;

   baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
      .clock(clock), .reset(reset), .load(tx_load), .half(tx_half_unused), .tick(tx_tick)
   );

   baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
      .clock(clock), .reset(reset), .load(rx_load), .half(rx_half), .tick(rx_tick)
   );

   // ---------------- transmitter ----------------
   assign tx_load = (tx_state_reg == TX_IDLE);

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_shift_next = tx_shift_reg;
      tx_bit_next   = tx_bit_reg;
      case (tx_state_reg)
         TX_IDLE: begin
            if (tx_wren_in) begin
               tx_shift_next = tx_data_in;
               tx_bit_next   = '0;
               tx_state_next = TX_START;
            end
         end
         TX_START: if (tx_tick) tx_state_next = TX_DATA;
         TX_DATA: begin
            if (tx_tick) begin
               tx_shift_next = {1'b1, tx_shift_reg[7:1]};
               if (tx_bit_reg == LAST_BIT) tx_state_next = TX_STOP;
               else                        tx_bit_next   = tx_bit_reg + 3'd1;
            end
         end
         TX_STOP: if (tx_tick) tx_state_next = TX_IDLE;
         default: tx_state_next = TX_IDLE;
      endcase
      // Line level is registered from the next state so the pin never glitches.
      tx_line_next = 1'b1;
      if (tx_state_next == TX_START)     tx_line_next = 1'b0;
      else if (tx_state_next == TX_DATA) tx_line_next = tx_shift_next[0];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         tx_state_reg <= TX_IDLE;
         tx_shift_reg <= '0;
         tx_bit_reg   <= '0;
         tx_line_reg  <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_shift_reg <= tx_shift_next;
         tx_bit_reg   <= tx_bit_next;
         tx_line_reg  <= tx_line_next;
      end
   end

   assign tx_ready_out = (tx_state_reg == TX_IDLE);
   assign uart_tx_out  = tx_line_reg;

   // ---------------- receiver ----------------
   // Synchronizer resets low so a line must be seen high before a start edge can register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_meta_reg <= 1'b0;
         rx_sync_reg <= 1'b0;
         rx_prev_reg <= 1'b0;
      end else begin
         rx_meta_reg <= uart_rx_in;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign rx_fall = rx_prev_reg & ~rx_sync_reg;

   always_comb begin
      rx_state_next   = rx_state_reg;
      rx_shift_next   = rx_shift_reg;
      rx_bit_next     = rx_bit_reg;
      rx_ferr_next    = rx_ferr_reg;
      rx_load         = 1'b0;
      rx_deliver      = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            rx_load = 1'b1;
            if (rx_fall) rx_state_next = RX_START;
         end
         RX_START: begin
            if (rx_half) begin
               if (!rx_sync_reg) begin
                  rx_load       = 1'b1;
                  rx_bit_next   = '0;
                  rx_state_next = RX_DATA;
               end else begin
                  rx_state_next = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
               if (rx_bit_reg == LAST_BIT) rx_state_next = RX_STOP;
               else                        rx_bit_next   = rx_bit_reg + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_state_next = RX_IDLE;
               if (rx_sync_reg) rx_deliver   = 1'b1;
               else             rx_ferr_next = 1'b1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase

      rx_valid_next   = rx_valid_reg;
      rx_data_next    = rx_data_reg;
      rx_overrun_next = rx_overrun_reg;
      if (rx_rden_in && rx_valid_reg) rx_valid_next = 1'b0;
      // A read in the same cycle frees the holding register, so the new byte is not lost.
      if (rx_deliver) begin
         if (rx_valid_reg && !rx_rden_in) begin
            rx_overrun_next = 1'b1;
         end else begin
            rx_data_next  = rx_shift_next;
            rx_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_state_reg   <= RX_IDLE;
         rx_shift_reg   <= '0;
         rx_bit_reg     <= '0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
         rx_ferr_reg    <= 1'b0;
      end else begin
         rx_state_reg   <= rx_state_next;
         rx_shift_reg   <= rx_shift_next;
         rx_bit_reg     <= rx_bit_next;
         rx_data_reg    <= rx_data_next;
         rx_valid_reg   <= rx_valid_next;
         rx_overrun_reg <= rx_overrun_next;
         rx_ferr_reg    <= rx_ferr_next;
      end
   end

   assign rx_data_out      = rx_data_reg;
   assign rx_valid_out     = rx_valid_reg;
   assign rx_overrun_out   = rx_overrun_reg;
   assign rx_frame_err_out = rx_ferr_reg;

endmodule

// File: tb/tb_serial_uart.sv
// Directed bench for serial_uart: TX frame monitor and RX byte monitor check against expected queues.
module tb_serial_uart;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] tx_data_in;
   logic       tx_wren_in;
   logic       tx_ready_out;
   logic       rx_rden_in;
   logic [7:0] rx_data_out;
   logic       rx_valid_out;
   logic       uart_rx_in;
   logic       uart_tx_out;
   logic       rx_overrun_out;
   logic       rx_frame_err_out;
   logic       loopback;
   logic       rx_drive;

   int cmp_count  = 0;
   int fail_count = 0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];

   always #5 clock = ~clock;

   assign uart_rx_in = loopback ? uart_tx_out : rx_drive;

   serial_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset),
      .tx_data_in(tx_data_in), .tx_wren_in(tx_wren_in), .tx_ready_out(tx_ready_out),
      .rx_rden_in(rx_rden_in), .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
      .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
      .rx_overrun_out(rx_overrun_out), .rx_frame_err_out(rx_frame_err_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic unexpected(input string name);
      cmp_count++;
      fail_count++;
      $display("FAIL %s: output with nothing expected", name);
   endtask

   // TX monitor: decode each frame at bit midpoints; a reset abandons a frame in progress.
   logic       tm_active = 1'b0;
   logic       tm_prev   = 1'b1;
   int         tm_cnt    = 0;
   logic [9:0] tm_bits   = '0;

   always @(negedge clock) begin
      if (reset !== 1'b1) begin
         tm_active = 1'b0;
      end else begin
         if (!tm_active && tm_prev && uart_tx_out === 1'b0) begin
            tm_active = 1'b1;
            tm_cnt    = 0;
         end else if (tm_active) begin
            tm_cnt++;
         end
         if (tm_active && (tm_cnt % CPB) == CPB / 2) begin
            tm_bits[tm_cnt / CPB] = uart_tx_out;
            if (tm_cnt / CPB == 9) begin
               tm_active = 1'b0;
               if (tx_exp_q.size() == 0) unexpected("tx_frame");
               else begin
                  logic [7:0] e;
                  e = tx_exp_q.pop_front();
                  check("tx_frame", 32'(tm_bits), 32'({1'b1, e, 1'b0}));
               end
            end
         end
      end
      tm_prev = uart_tx_out;
   end

   // RX monitor: every new presentation of rx_valid_out consumes one expected byte.
   logic rm_prev = 1'b0;

   always @(negedge clock) begin
      if (rx_valid_out === 1'b1 && !rm_prev) begin
         if (rx_exp_q.size() == 0) unexpected("rx_byte");
         else check("rx_byte", 32'(rx_data_out), 32'(rx_exp_q.pop_front()));
      end
      rm_prev = (rx_valid_out === 1'b1);
   end

   task automatic tx_frame(input logic [7:0] d, input int dup_at);
      int low;
      @(negedge clock);
      tx_data_in = d;
      tx_wren_in = 1'b1;
      tx_exp_q.push_back(d);
      @(negedge clock);
      tx_wren_in = 1'b0;
      check("tx_ready_drop", 32'(tx_ready_out), 32'd0);
      check("tx_start_low", 32'(uart_tx_out), 32'd0);
      low = 1;
      for (int i = 0; i < 400; i++) begin
         if (dup_at > 0 && low == dup_at) begin
            tx_data_in = 8'h77;
            tx_wren_in = 1'b1;
         end else begin
            tx_wren_in = 1'b0;
         end
         @(negedge clock);
         if (tx_ready_out === 1'b1) break;
         low++;
      end
      tx_wren_in = 1'b0;
      check("tx_ready_low_cycles", 32'(low), 32'd40);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_drive = f[k];
         repeat (CPB) @(negedge clock);
      end
      rx_drive = 1'b1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 200; i++) begin
         if (rx_valid_out === 1'b1) break;
         @(negedge clock);
      end
      check("rx_valid_wait", 32'(rx_valid_out), 32'd1);
   endtask

   task automatic rx_read(input logic [7:0] keep);
      @(negedge clock);
      rx_rden_in = 1'b1;
      @(negedge clock);
      rx_rden_in = 1'b0;
      check("rx_valid_cleared", 32'(rx_valid_out), 32'd0);
      check("rx_data_kept", 32'(rx_data_out), 32'(keep));
   endtask

   initial begin
      reset      = 1'b0;
      tx_data_in = 8'h00;
      tx_wren_in = 1'b0;
      rx_rden_in = 1'b0;
      loopback   = 1'b0;
      rx_drive   = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_tx_line", 32'(uart_tx_out), 32'd1);
      check("rst_tx_ready", 32'(tx_ready_out), 32'd1);
      check("rst_rx_valid", 32'(rx_valid_out), 32'd0);
      check("rst_rx_data", 32'(rx_data_out), 32'h00);
      check("rst_overrun", 32'(rx_overrun_out), 32'd0);
      check("rst_frame_err", 32'(rx_frame_err_out), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // 0xA5 frame shape and ready-low length
      tx_frame(8'hA5, 0);
      // second write 5 cycles into a frame must be dropped
      tx_frame(8'h5A, 5);
      repeat (50) @(negedge clock);
      check("tx_no_extra_frame", 32'(tx_exp_q.size()), 32'd0);
      check("tx_idle_line", 32'(uart_tx_out), 32'd1);

      // loopback
      loopback = 1'b1;
      rx_exp_q.push_back(8'h3C);
      tx_frame(8'h3C, 0);
      wait_valid();
      rx_read(8'h3C);
      loopback = 1'b0;
      repeat (5) @(negedge clock);

      // overrun: second byte lost, first kept
      rx_exp_q.push_back(8'h11);
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      repeat (10) @(negedge clock);
      check("ovr_valid", 32'(rx_valid_out), 32'd1);
      check("ovr_data", 32'(rx_data_out), 32'h11);
      check("ovr_flag", 32'(rx_overrun_out), 32'd1);
      check("ovr_no_ferr", 32'(rx_frame_err_out), 32'd0);
      rx_read(8'h11);

      // reset with the line held low: no start may be detected afterwards
      rx_drive = 1'b0;
      reset    = 1'b0;
      repeat (2) @(negedge clock);
      check("rst2_overrun", 32'(rx_overrun_out), 32'd0);
      reset = 1'b1;
      repeat (60) @(negedge clock);
      check("lowline_ferr", 32'(rx_frame_err_out), 32'd0);
      check("lowline_valid", 32'(rx_valid_out), 32'd0);
      rx_drive = 1'b1;
      repeat (6) @(negedge clock);

      // single-cycle glitch is rejected
      rx_drive = 1'b0;
      @(negedge clock);
      rx_drive = 1'b1;
      repeat (30) @(negedge clock);
      check("glitch_valid", 32'(rx_valid_out), 32'd0);
      check("glitch_overrun", 32'(rx_overrun_out), 32'd0);
      check("glitch_ferr", 32'(rx_frame_err_out), 32'd0);

      // stop bit low
      send_rx(8'h55, 1'b0);
      repeat (10) @(negedge clock);
      check("ferr_valid", 32'(rx_valid_out), 32'd0);
      check("ferr_flag", 32'(rx_frame_err_out), 32'd1);

      // re-arms once the line is high again; error flag stays sticky
      rx_exp_q.push_back(8'h96);
      send_rx(8'h96, 1'b1);
      wait_valid();
      check("ferr_sticky", 32'(rx_frame_err_out), 32'd1);
      rx_read(8'h96);

      // reset during data bit 3 of a TX frame
      @(negedge clock);
      tx_data_in = 8'hC3;
      tx_wren_in = 1'b1;
      @(negedge clock);
      tx_wren_in = 1'b0;
      repeat (17) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("abort_tx_line", 32'(uart_tx_out), 32'd1);
      check("abort_tx_ready", 32'(tx_ready_out), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      tx_frame(8'hFF, 0);

      repeat (10) @(negedge clock);
      check("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
      check("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

   initial begin
      #200000;
      fail_count++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/serial_uart.md
SERIAL_UART -- requirements
Module: serial_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port tx_data_in  input  8  byte to transmit; driven by the processor's serial_out.
REQ-005 SHALL have port tx_wren_in  input  1  write strobe; driven by the processor's serial_wren_out.
REQ-006 SHALL have port tx_ready_out  output  1  transmitter can accept a byte; drives the processor's serial_ready_in.
REQ-007 SHALL have port rx_rden_in  input  1  read-acknowledge strobe; driven by the processor's serial_rden_out.
REQ-008 SHALL have port rx_data_out  output  8  received byte; drives the processor's serial_in.
REQ-009 SHALL have port rx_valid_out  output  1  rx_data_out holds an unread byte; drives the processor's serial_valid_in.
REQ-010 SHALL have port uart_rx_in  input  1  asynchronous serial line in; idle high.
REQ-011 SHALL have port uart_tx_out  output  1  serial line out; idle high.
REQ-012 SHALL have port rx_overrun_out  output  1  sticky flag: a received byte was lost.
REQ-013 SHALL have port rx_frame_err_out  output  1  sticky flag: a stop bit was sampled low.

Function
REQ-014 SHALL use the frame format 8N1: start bit 0, data bits LSB first, stop bit 1, each bit CLKS_PER_BIT cycles long.
REQ-015 TX FSM SHALL have the states TX_IDLE, TX_START, TX_DATA and TX_STOP, using a 3-bit bit index and a bit-period counter.
REQ-016 tx_ready_out SHALL be 1 only in TX_IDLE.
REQ-017 In TX_IDLE, tx_wren_in=1 SHALL latch tx_data_in, enter TX_START and drop tx_ready_out on the next edge.
REQ-018 uart_tx_out SHALL go low on the cycle after acceptance.
REQ-019 When tx_ready_out=0, tx_wren_in SHALL be ignored; no byte is latched or queued.
REQ-020 After the stop bit's last cycle, the TX FSM SHALL return to TX_IDLE; one full frame SHALL hold tx_ready_out low for exactly 10*CLKS_PER_BIT cycles.
REQ-021 uart_rx_in SHALL pass through a two-flop synchronizer before any use.
REQ-022 RX FSM SHALL have the states RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-023 A falling edge on the synchronized input in RX_IDLE SHALL enter RX_START.
REQ-024 The start bit SHALL be re-sampled at CLKS_PER_BIT/2 cycles; if it is high, the FSM SHALL return to RX_IDLE (glitch reject) with no flag set.
REQ-025 Data bits and the stop bit SHALL each be sampled once per CLKS_PER_BIT cycles, measured from the start-bit midpoint.
REQ-026 If the stop sample is 1, the byte SHALL be delivered: rx_data_out is updated and rx_valid_out=1 on the edge following the stop sample.
REQ-027 If the stop sample is 0, the byte SHALL be discarded and rx_frame_err_out set to 1; the FSM SHALL then wait in RX_IDLE for the line to return high before re-arming.
REQ-028 rx_rden_in with rx_valid_out=1 SHALL clear rx_valid_out on the next edge; rx_data_out SHALL retain its value.
REQ-029 rx_rden_in with rx_valid_out=0 SHALL have no effect.
REQ-030 Delivery while rx_valid_out=1 and rx_rden_in=0 SHALL discard the new byte, keep the old byte and set rx_overrun_out to 1.
REQ-031 Delivery coinciding with rx_rden_in=1 SHALL load the new byte, keep rx_valid_out=1 and leave rx_overrun_out unchanged.
REQ-032 The TX and RX paths SHALL be fully independent, so full-duplex operation is legal.

Reset
REQ-033 While reset=0 at an edge: uart_tx_out=1, tx_ready_out=1, rx_valid_out=0, rx_data_out=8'h00, rx_overrun_out=0, rx_frame_err_out=0, both FSMs in their idle state, all counters 0.
REQ-034 Reset asserted mid-frame SHALL abort that frame immediately: the TX line returns high and a partial RX byte is discarded.
REQ-035 After reset deasserts, RX SHALL not detect a start bit until the synchronized line has been seen high.

Structure
REQ-036 The state encodings (tx_state_t, rx_state_t) and the frame length constant FRAME_BITS=10 SHALL reside in the shared package serial_pkg.
REQ-037 The bit-period counter SHALL be one sub-module, baud_counter (load, half-period and tick outputs), instantiated once for TX and once for RX.

Verification
REQ-038 With CLKS_PER_BIT=4, writing 8'hA5 SHALL make uart_tx_out produce 0,1,0,1,0,0,1,0,1,1 in 4-cycle steps; tx_ready_out is low for exactly 40 cycles.
REQ-039 Looping uart_tx_out back to uart_rx_in and sending 8'h3C SHALL give rx_valid_out=1 with rx_data_out=8'h3C; one rx_rden_in pulse then clears rx_valid_out.
REQ-040 Receiving 8'h11 then 8'h22 with no read SHALL leave rx_data_out=8'h11 and rx_overrun_out=1.
REQ-041 A 1-cycle low glitch on uart_rx_in SHALL leave rx_valid_out=0 and both flags 0; a frame with stop bit 0 SHALL leave rx_valid_out=0 and rx_frame_err_out=1.
REQ-042 Asserting reset during bit 3 of a TX frame SHALL give uart_tx_out=1 and tx_ready_out=1 on the next edge; a write 2 cycles later SHALL produce a clean 8'hFF frame.
REQ-043 A second tx_wren_in issued 5 cycles after an accepted write SHALL be ignored, so exactly one frame is transmitted.
